// File: rtl/pipe_pkg.sv
// Shared opcodes and memory-stage FSM encoding for the 32-bit pipeline.
package pipe_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_SW     = 4'b0011;
  localparam logic [3:0] OP_LW     = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } mem_state_e;

  // True for opcodes that need a data-memory transaction.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory handshake sequencer: drives req through REQ/WAIT_R and
// flags rvalid that arrives while no load is waiting for it.
module dmem_if_fsm
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture_i,       // MEM slot loads a new instruction this edge
  input  logic       cap_is_mem_i,    // that instruction is a load or store
  input  logic       slot_is_store_i, // instruction currently in MEM is a store
  input  logic       dmem_gnt_i,
  input  logic       dmem_rvalid_i,
  output mem_state_e state_o,
  output logic       dmem_req_o,
  output logic       proto_err_o
);

  mem_state_e state_q;
  logic       req_q;
  logic       err_q;

  // Sequencing of one memory access; a capture always restarts the FSM for the new slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (dmem_rvalid_i && (state_q != ST_WAIT_R)) begin
        err_q <= 1'b1;
      end
      if (capture_i) begin
        state_q <= cap_is_mem_i ? ST_REQ : ST_IDLE;
        req_q   <= cap_is_mem_i;
      end else begin
        case (state_q)
          ST_REQ: begin
            if (dmem_gnt_i) begin
              state_q <= slot_is_store_i ? ST_IDLE : ST_WAIT_R;
              req_q   <= 1'b0;
            end
          end
          ST_WAIT_R: begin
            if (dmem_rvalid_i) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o     = state_q;
  assign dmem_req_o  = req_q;
  assign proto_err_o = err_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// Memory-access stage with MEM and WB pipeline registers. Holds one
// instruction in MEM, runs its load/store, and backpressures EX until done.
module mem_wb_pipe
  import pipe_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int bitwidth            = 32,
  parameter int STALL_CNT_W         = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ex_valid,
  output logic                           ex_ready,
  input  logic                           ex_flush,
  input  logic [3:0]                     ex_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_index,
  input  logic [bitwidth-1:0]            ex_result,
  input  logic [bitwidth-1:0]            ex_store_data,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [bitwidth-1:0]            dmem_addr,
  output logic [bitwidth-1:0]            dmem_wdata,
  input  logic                           dmem_gnt,
  input  logic                           dmem_rvalid,
  input  logic [bitwidth-1:0]            dmem_rdata,
  output logic [3:0]                     MEM_opcode,
  output logic [REG_INDEX_BIT_WIDTH-1:0] MEM_index,
  output logic [bitwidth-1:0]            MEM_data,
  output logic [3:0]                     WB_opcode,
  output logic [REG_INDEX_BIT_WIDTH-1:0] WB_index,
  output logic [bitwidth-1:0]            WB_data,
  output logic                           wb_valid,
  output logic                           proto_err,
  output logic [STALL_CNT_W-1:0]         mem_stall_cycles
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  // MEM slot
  logic                           mem_valid_q, mem_valid_d;
  logic [3:0]                     mem_opcode_q, mem_opcode_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] mem_index_q, mem_index_d;
  logic [bitwidth-1:0]            mem_data_q, mem_data_d;
  logic [bitwidth-1:0]            mem_wdata_q, mem_wdata_d;
  // WB slot
  logic                           wb_valid_q, wb_valid_d;
  logic [3:0]                     wb_opcode_q, wb_opcode_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_index_q, wb_index_d;
  logic [bitwidth-1:0]            wb_data_q, wb_data_d;
  logic [STALL_CNT_W-1:0]         stall_q, stall_d;

  mem_state_e state;
  logic       slot_is_store;
  logic       slot_is_load;
  logic       advance;
  logic       capture;

  assign slot_is_store = (mem_opcode_q == OP_SW);
  assign slot_is_load  = (mem_opcode_q == OP_LW);

  // MEM may hand its instruction to WB this cycle.
  always_comb begin
    advance = 1'b0;
    if (mem_valid_q) begin
      case (state)
        ST_IDLE:   advance = !is_mem_op(mem_opcode_q);
        ST_REQ:    advance = slot_is_store && dmem_gnt;
        ST_WAIT_R: advance = slot_is_load && dmem_rvalid;
        default:   advance = 1'b0;
      endcase
    end
  end

  // A slot that empties this edge can take the next instruction on the same edge.
  assign ex_ready = !mem_valid_q || advance;
  assign capture  = ex_valid && ex_ready && !ex_flush;

  dmem_if_fsm u_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture_i       (capture),
    .cap_is_mem_i    (is_mem_op(ex_opcode)),
    .slot_is_store_i (slot_is_store),
    .dmem_gnt_i      (dmem_gnt),
    .dmem_rvalid_i   (dmem_rvalid),
    .state_o         (state),
    .dmem_req_o      (dmem_req),
    .proto_err_o     (proto_err)
  );

  // Next-state for MEM slot, WB slot and stall counter.
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_opcode_d = mem_opcode_q;
    mem_index_d  = mem_index_q;
    mem_data_d   = mem_data_q;
    mem_wdata_d  = mem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_opcode_d  = OP_NOP;
    wb_index_d   = wb_index_q;
    wb_data_d    = wb_data_q;
    stall_d      = stall_q;

    if (capture) begin
      mem_valid_d  = 1'b1;
      mem_opcode_d = ex_opcode;
      mem_index_d  = ex_index;
      mem_data_d   = ex_result;
      mem_wdata_d  = ex_store_data;
    end else if (advance || !mem_valid_q) begin
      mem_valid_d  = 1'b0;
      mem_opcode_d = OP_NOP;
    end

    if (advance) begin
      wb_valid_d  = 1'b1;
      wb_opcode_d = mem_opcode_q;
      wb_index_d  = mem_index_q;
      wb_data_d   = slot_is_load ? dmem_rdata : mem_data_q;
    end

    if (ex_valid && !ex_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  // Pipeline registers; reset clears everything so a dropped access leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q  <= 1'b0;
      mem_opcode_q <= OP_NOP;
      mem_index_q  <= '0;
      mem_data_q   <= '0;
      mem_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_opcode_q  <= OP_NOP;
      wb_index_q   <= '0;
      wb_data_q    <= '0;
      stall_q      <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_opcode_q <= mem_opcode_d;
      mem_index_q  <= mem_index_d;
      mem_data_q   <= mem_data_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_opcode_q  <= wb_opcode_d;
      wb_index_q   <= wb_index_d;
      wb_data_q    <= wb_data_d;
      stall_q      <= stall_d;
    end
  end

  assign MEM_opcode       = mem_opcode_q;
  assign MEM_index        = mem_index_q;
  assign MEM_data         = mem_data_q;
  assign dmem_we          = slot_is_store;
  assign dmem_addr        = mem_data_q;
  assign dmem_wdata       = mem_wdata_q;
  assign WB_opcode        = wb_opcode_q;
  assign WB_index         = wb_index_q;
  assign WB_data          = wb_data_q;
  assign wb_valid         = wb_valid_q;
  assign mem_stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: ALU op, load, store, flush, protocol error, reset mid-load.
module tb_mem_wb_pipe;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_flush;
  logic [3:0]  ex_opcode;
  logic [3:0]  ex_index;
  logic [31:0] ex_result, ex_store_data;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  MEM_opcode, MEM_index, WB_opcode, WB_index;
  logic [31:0] MEM_data, WB_data;
  logic        wb_valid, proto_err;
  logic [15:0] mem_stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .ex_opcode(ex_opcode), .ex_index(ex_index), .ex_result(ex_result),
    .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .MEM_opcode(MEM_opcode), .MEM_index(MEM_index), .MEM_data(MEM_data),
    .WB_opcode(WB_opcode), .WB_index(WB_index), .WB_data(WB_data),
    .wb_valid(wb_valid), .proto_err(proto_err), .mem_stall_cycles(mem_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [3:0] idx,
                       input logic [31:0] res, input logic [31:0] sd);
    ex_valid      = 1'b1;
    ex_opcode     = op;
    ex_index      = idx;
    ex_result     = res;
    ex_store_data = sd;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_mem_op"},  MEM_opcode, OP_NOP);
    check({pfx, "_mem_idx"}, MEM_index, 0);
    check({pfx, "_mem_dat"}, MEM_data, 0);
    check({pfx, "_wb_op"},   WB_opcode, OP_NOP);
    check({pfx, "_wb_idx"},  WB_index, 0);
    check({pfx, "_wb_dat"},  WB_data, 0);
    check({pfx, "_req"},     dmem_req, 0);
    check({pfx, "_we"},      dmem_we, 0);
    check({pfx, "_addr"},    dmem_addr, 0);
    check({pfx, "_wdata"},   dmem_wdata, 0);
    check({pfx, "_wbv"},     wb_valid, 0);
    check({pfx, "_perr"},    proto_err, 0);
    check({pfx, "_stall"},   mem_stall_cycles, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_flush = 1'b0; ex_opcode = OP_NOP; ex_index = '0;
    ex_result = '0; ex_store_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    #3;
    check_reset_state("rst");
    check("rst_ready", ex_ready, 1);
    tick;
    rst_n = 1'b1;

    // Non-memory op: one cycle in MEM, then WB.
    offer(4'b0001, 4'd5, 32'h1234, 32'h0);
    #2 check("alu_ready0", ex_ready, 1);
    tick;
    ex_valid = 1'b0;
    check("alu_mem_op",  MEM_opcode, 4'b0001);
    check("alu_mem_idx", MEM_index, 5);
    check("alu_mem_dat", MEM_data, 32'h1234);
    check("alu_req",     dmem_req, 0);
    check("alu_wbv0",    wb_valid, 0);
    check("alu_ready1",  ex_ready, 1);
    tick;
    check("alu_wb_dat", WB_data, 32'h1234);
    check("alu_wb_idx", WB_index, 5);
    check("alu_wb_op",  WB_opcode, 4'b0001);
    check("alu_wbv1",   wb_valid, 1);
    check("alu_mem_nop", MEM_opcode, OP_NOP);
    tick;
    check("alu_wbv2",  wb_valid, 0);
    check("alu_wbop2", WB_opcode, OP_NOP);

    // Load: gnt on third REQ cycle, rvalid three cycles after gnt.
    offer(OP_LW, 4'd7, 32'h100, 32'h0);
    tick;
    offer(4'b0001, 4'd2, 32'h55, 32'h0);
    #2;
    check("ld_req",   dmem_req, 1);
    check("ld_we",    dmem_we, 0);
    check("ld_addr",  dmem_addr, 32'h100);
    check("ld_rdy_c1", ex_ready, 0);
    tick;
    check("ld_rdy_c2", ex_ready, 0);
    tick;
    dmem_gnt = 1'b1;
    #2;
    check("ld_req_c3", dmem_req, 1);
    check("ld_rdy_c3", ex_ready, 0);
    tick;
    dmem_gnt = 1'b0;
    #2;
    check("ld_req_c4", dmem_req, 0);
    check("ld_rdy_c4", ex_ready, 0);
    tick;
    check("ld_rdy_c5", ex_ready, 0);
    tick;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    #2 check("ld_rdy_c6", ex_ready, 1);
    tick;
    dmem_rvalid = 1'b0;
    ex_valid    = 1'b0;
    check("ld_wb_dat", WB_data, 32'hDEADBEEF);
    check("ld_wb_op",  WB_opcode, OP_LW);
    check("ld_wb_idx", WB_index, 7);
    check("ld_wbv",    wb_valid, 1);
    check("ld_stall",  mem_stall_cycles, 5);
    check("ld_next_op",  MEM_opcode, 4'b0001);
    check("ld_next_dat", MEM_data, 32'h55);
    tick;
    check("ld_after_op", WB_opcode, 4'b0001);
    check("ld_after_dat", WB_data, 32'h55);

    // Store granted on first REQ cycle; next op captured on the same edge.
    offer(OP_SW, 4'd3, 32'h40, 32'hA5A5A5A5);
    tick;
    offer(4'b0001, 4'd9, 32'h77, 32'h0);
    dmem_gnt = 1'b1;
    #2;
    check("st_req",   dmem_req, 1);
    check("st_we",    dmem_we, 1);
    check("st_addr",  dmem_addr, 32'h40);
    check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("st_ready", ex_ready, 1);
    tick;
    dmem_gnt = 1'b0;
    ex_valid = 1'b0;
    check("st_wb_op",   WB_opcode, OP_SW);
    check("st_wb_idx",  WB_index, 3);
    check("st_wb_dat",  WB_data, 32'h40);
    check("st_wbv",     wb_valid, 1);
    check("st_next_op", MEM_opcode, 4'b0001);
    check("st_next_idx", MEM_index, 9);
    check("st_req_off", dmem_req, 0);
    tick;
    tick;

    // Load in WAIT_R completes while a flushed load is offered.
    offer(OP_LW, 4'd4, 32'h200, 32'h0);
    tick;
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    offer(OP_LW, 4'd8, 32'h300, 32'h0);
    ex_flush    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    tick;
    ex_valid = 1'b0; ex_flush = 1'b0; dmem_rvalid = 1'b0;
    check("fl_mem_nop", MEM_opcode, OP_NOP);
    check("fl_req",     dmem_req, 0);
    check("fl_wb_dat",  WB_data, 32'hCAFEF00D);
    check("fl_wb_idx",  WB_index, 4);
    check("fl_wbv",     wb_valid, 1);
    check("fl_perr",    proto_err, 0);
    tick;
    check("fl_req2", dmem_req, 0);

    // Stray rvalid while idle.
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111;
    tick;
    dmem_rvalid = 1'b0;
    check("pe_flag",   proto_err, 1);
    check("pe_wbv",    wb_valid, 0);
    check("pe_wb_dat", WB_data, 32'hCAFEF00D);
    check("pe_wb_op",  WB_opcode, OP_NOP);
    tick;
    check("pe_sticky", proto_err, 1);
    check("pe_stall",  mem_stall_cycles, 5);

    // Reset while a load waits for rvalid.
    offer(OP_LW, 4'd6, 32'h300, 32'h0);
    tick;
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    #2 check("rw_ready", ex_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_state("rw");
    check("rw_ready0", ex_ready, 1);
    #1 rst_n = 1'b1;
    tick;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h9999;
    tick;
    dmem_rvalid = 1'b0;
    check("rw_wbv",    wb_valid, 0);
    check("rw_wb_dat", WB_data, 0);
    check("rw_perr",   proto_err, 1);
    tick;
    check("rw_wbv2", wb_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
